// File: rtl/uart_img_streamer_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_img_streamer_if
// Purpose : Memory read port plus UART tx/rx byte handshakes of the image streamer.
// Rev     : 1.0  initial release
// ============================================================================
interface uart_img_streamer_if #(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 1
);
  localparam int c_MEM_AW = ADDR_W - $clog2(WORD_BYTES);

  logic                    mem_rd;
  logic [c_MEM_AW-1:0]     mem_addr;
  logic [8*WORD_BYTES-1:0] mem_rdata;
  logic                    tx_valid;
  logic [7:0]              tx_data;
  logic                    tx_busy;
  logic                    rx_valid;
  logic [7:0]              rx_data;

  modport master (
    output mem_rd, mem_addr, tx_valid, tx_data,
    input  mem_rdata, tx_busy, rx_valid, rx_data
  );

  modport slave (
    input  mem_rd, mem_addr, tx_valid, tx_data,
    output mem_rdata, tx_busy, rx_valid, rx_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_img_streamer.sv
`default_nettype none
// ============================================================================
// Module  : uart_img_streamer
// Purpose : Streams a memory image as SYNC/length/payload[/checksum] over a UART
//           and waits for an ack byte. Define UART_IMG_CSUM_EN for the checksum.
// Rev     : 1.0  initial release
// ============================================================================
module uart_img_streamer #(
  parameter int         ADDR_W      = 16,
  parameter int         WORD_BYTES  = 1,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter int         ACK_TIMEOUT = 100000
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                start,
  input  logic [ADDR_W-1:0]   img_len,
  uart_img_streamer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W-1:0]   byte_cnt
);

  localparam int c_LEN_BYTES = (ADDR_W + 7) / 8;
  localparam int c_LC_W      = $clog2(c_LEN_BYTES + 1);
  localparam int c_OFF_W     = $clog2(WORD_BYTES);
  localparam int c_TMR_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(ACK_TIMEOUT - 1);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_SYNC     = 3'd1;
  localparam logic [2:0] c_ST_LEN      = 3'd2;
  localparam logic [2:0] c_ST_FETCH    = 3'd3;
  localparam logic [2:0] c_ST_WAIT_RD  = 3'd4;
  localparam logic [2:0] c_ST_SEND     = 3'd5;
  localparam logic [2:0] c_ST_ACK_WAIT = 3'd6;
`ifdef UART_IMG_CSUM_EN
  localparam logic [2:0] c_ST_CSUM     = 3'd7;
  localparam logic [2:0] c_ST_AFTER    = c_ST_CSUM;
`else
  localparam logic [2:0] c_ST_AFTER    = c_ST_ACK_WAIT;
`endif

  logic [2:0]               r_state;
  logic [ADDR_W-1:0]        r_img_len;
  logic [ADDR_W-1:0]        r_byte_cnt;
  logic [8*c_LEN_BYTES-1:0] r_len_sh;
  logic [c_LC_W-1:0]        r_len_left;
  logic [8*WORD_BYTES-1:0]  r_word;
  logic                     r_tx_valid;
  logic [7:0]               r_tx_data;
  logic                     r_guard;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_error;
  logic [c_TMR_W-1:0]       r_timer;
`ifdef UART_IMG_CSUM_EN
  logic [7:0]               r_csum;
`endif

  logic                     w_can_tx;
  logic [ADDR_W-1:0]        w_cnt_next;
  logic                     w_word_end;
  logic [8*c_LEN_BYTES-1:0] w_len_ext;

  // The cycle after a strobe is a guard cycle: tx_busy is not trusted there.
  assign w_can_tx   = !bus.tx_busy && !r_tx_valid && !r_guard;
  assign w_cnt_next = r_byte_cnt + ADDR_W'(1);

  always_comb begin
    w_len_ext               = '0;
    w_len_ext[ADDR_W-1:0]   = img_len;
  end

  // Fetches always start on a word boundary, so a word is exhausted when the
  // next byte count lands on the next boundary.
  generate
    if (WORD_BYTES > 1) begin : g_multi_byte
      assign w_word_end = (w_cnt_next[c_OFF_W-1:0] == '0);
    end else begin : g_single_byte
      assign w_word_end = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= c_ST_IDLE;
      r_img_len  <= '0;
      r_byte_cnt <= '0;
      r_len_sh   <= '0;
      r_len_left <= '0;
      r_word     <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_guard    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_timer    <= '0;
`ifdef UART_IMG_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_guard    <= r_tx_valid;
      r_tx_valid <= 1'b0;
      r_timer    <= (r_state == c_ST_ACK_WAIT) ? r_timer + c_TMR_W'(1) : '0;

      case (r_state)
        c_ST_IDLE: begin
          if (start && !r_busy) begin
            r_img_len  <= img_len;
            r_len_sh   <= w_len_ext;
            r_len_left <= c_LC_W'(c_LEN_BYTES);
            r_byte_cnt <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
`ifdef UART_IMG_CSUM_EN
            r_csum     <= '0;
`endif
            r_state    <= c_ST_SYNC;
          end
        end

        c_ST_SYNC: begin
          if (w_can_tx) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= SYNC_BYTE;
            r_state    <= c_ST_LEN;
          end
        end

        c_ST_LEN: begin
          if (w_can_tx) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_len_sh[7:0];
            r_len_sh   <= r_len_sh >> 8;
            r_len_left <= r_len_left - c_LC_W'(1);
            if (r_len_left == c_LC_W'(1))
              r_state <= (r_img_len == '0) ? c_ST_AFTER : c_ST_FETCH;
          end
        end

        c_ST_FETCH: r_state <= c_ST_WAIT_RD;

        c_ST_WAIT_RD: begin
          r_word  <= bus.mem_rdata;
          r_state <= c_ST_SEND;
        end

        c_ST_SEND: begin
          if (w_can_tx) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_word[7:0];
            r_word     <= r_word >> 8;
            r_byte_cnt <= w_cnt_next;
`ifdef UART_IMG_CSUM_EN
            r_csum     <= r_csum + r_word[7:0];
`endif
            if (w_cnt_next == r_img_len)
              r_state <= c_ST_AFTER;
            else if (w_word_end)
              r_state <= c_ST_FETCH;
          end
        end

`ifdef UART_IMG_CSUM_EN
        c_ST_CSUM: begin
          if (w_can_tx) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_csum;
            r_state    <= c_ST_ACK_WAIT;
          end
        end
`endif

        c_ST_ACK_WAIT: begin
          // A received byte wins over a timeout landing in the same cycle.
          if (bus.rx_valid) begin
            if (bus.rx_data == ACK_BYTE) r_done  <= 1'b1;
            else                         r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= c_ST_IDLE;
          end else if (r_timer == c_TMR_LAST) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= c_ST_IDLE;
          end
        end

        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.mem_rd   = (r_state == c_ST_FETCH);
  assign bus.mem_addr = r_byte_cnt[ADDR_W-1:c_OFF_W];
  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_data  = r_tx_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign byte_cnt     = r_byte_cnt;

endmodule
`default_nettype wire

// File: doc/uart_img_streamer.md
Name: uart_img_streamer

Overview:
- Synthesizable image-download master: reads an image from a word-wide memory port, serialises it byte-wise into a UART transmitter, then waits for an acknowledge byte on the UART receiver.
- Frame on the wire: SYNC, length, payload, optional checksum.
- Used by the bring-up controller and the bench harness to push a software image into the SoC's UART upgrade path.
- Generalises the plain byte pump with configurable word width, image length, framing, ack/timeout and status.

Parameters:
- ADDR_W, 16: byte-address and length width; length field is LEN_BYTES = ceil(ADDR_W/8) bytes.
- WORD_BYTES, 1: memory word width in bytes (1, 2 or 4); bytes leave LSB-first.
- SYNC_BYTE, 8'hA5: first byte of every frame.
- ACK_BYTE, 8'h06: byte from the receiver that signals success.
- ACK_TIMEOUT, 100000: clk cycles to wait for ack before flagging error; must be >= 1.

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous, active-low reset
- start  in  1  one-cycle start pulse; honoured only when busy=0
- img_len  in  ADDR_W  payload length in bytes; sampled on accepted start
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W-$clog2(WORD_BYTES)  word address
- mem_rdata  in  8*WORD_BYTES  read data, valid exactly 1 cycle after mem_rd
- tx_valid  out  1  one-cycle byte strobe to UART tx
- tx_data  out  8  byte to send; held stable from strobe until next strobe
- tx_busy  in  1  UART tx busy
- rx_valid  in  1  UART rx byte strobe
- rx_data  in  8  UART rx byte
- busy  out  1  high from accepted start until done/error
- done  out  1  sticky success flag; cleared by next accepted start
- error  out  1  sticky failure flag; cleared by next accepted start
- byte_cnt  out  ADDR_W  payload bytes sent so far

Behaviour:
- Reset: every output is 0; FSM returns to IDLE and the ack timer clears. Reset mid-frame aborts with no further strobes; no done/error is produced.
- FSM states: IDLE -> SYNC -> LEN -> FETCH -> WAIT_RD -> SEND -> (CSUM) -> ACK_WAIT -> IDLE.
- IDLE:
  - start & ~busy latches img_len, clears done/error/byte_cnt and sets busy.
  - start while busy is ignored.
- Tx handshake:
  - A byte is issued as a single-cycle tx_valid when tx_busy=0 and tx_valid was 0 in the previous cycle.
  - After each strobe, one guard cycle passes before tx_busy is sampled again.
  - Never two strobes in adjacent cycles.
- SYNC: send SYNC_BYTE.
- LEN: send LEN_BYTES bytes of img_len, LSB-first.
- Payload:
  - FETCH asserts mem_rd for 1 cycle at word address byte_cnt/WORD_BYTES.
  - WAIT_RD captures mem_rdata into a shift register.
  - SEND emits bytes at offsets (byte_cnt mod WORD_BYTES) through WORD_BYTES-1.
  - byte_cnt increments on each payload strobe.
  - Refetch when the word is exhausted and byte_cnt < img_len.
  - A partial last word emits only the remaining bytes.
- img_len=0: no memory reads; go from LEN (or CSUM) directly to ACK_WAIT.
- ACK_WAIT:
  - Timer starts at 0 on entry.
  - rx_valid & rx_data==ACK_BYTE -> done=1.
  - rx_valid with any other byte -> error=1.
  - Timer reaching ACK_TIMEOUT -> error=1.
  - Every exit clears busy the same cycle the flag rises.
- rx_valid outside ACK_WAIT is ignored.
- byte_cnt wraps at 2^ADDR_W; img_len up to 2^ADDR_W-1 is supported.

Optional Feature:
- Macro UART_IMG_CSUM_EN.
- Defined: CSUM state after the last payload byte sends one byte = 8-bit modulo-256 sum of all payload bytes (length and sync bytes excluded). With img_len=0, CSUM sends 8'h00.
- Undefined: no CSUM state; ACK_WAIT follows the last payload byte.

Test Plan:
- WORD_BYTES=1, img_len=4, mem = 11 22 33 44, ack 06 -> tx sequence A5 04 00 11 22 33 44 (+AA with CSUM_EN); done=1, error=0, byte_cnt=4, 4 mem_rd pulses.
- WORD_BYTES=4, img_len=6, words 0x44332211, 0x88776655 -> payload 11 22 33 44 55 66; exactly 2 mem_rd pulses; bytes 77 88 never sent.
- img_len=0, ack 06 -> tx A5 00 00 (+00 with CSUM_EN); no mem_rd; done=1.
- After the last byte, rx byte 15 -> error=1, done=0, busy=0. Separate run with no rx and ACK_TIMEOUT=50 -> error rises exactly 50 cycles after ACK_WAIT entry.
- tx_busy held high for 200 cycles mid-payload -> no strobe during that window; frame resumes intact; tx_valid never high two cycles in a row.
- rstb low during payload byte 2, then start again with img_len=2 -> all outputs 0 during reset; new frame begins A5 02 00 with byte_cnt restarting at 0; start pulse while busy ignored.
